display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_display_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Fixed-priority arbiter that selects one of three digit/mode sources
// for a four-digit seven-segment driver, holding each grant for a minimum tick count.
module display_arbiter #(
  parameter int unsigned HOLD_TICKS = 2,
  parameter logic [1:0]  IDLE_MODE  = 2'b00
) (
  input  logic        f_clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [15:0] digits0,
  input  logic [15:0] digits1,
  input  logic [15:0] digits2,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  input  logic [1:0]  mode2,
  output logic [2:0]  gnt,
  output logic [3:0]  seg1,
  output logic [3:0]  seg2,
  output logic [3:0]  seg3,
  output logic [3:0]  seg4,
  output logic [1:0]  mode,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    LINGER
  } state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_TICKS);

  state_t      state;
  state_t      state_n;
  logic [2:0]  gnt_n;
  logic [7:0]  cnt;
  logic [7:0]  cnt_n;
  logic [7:0]  cnt_dec;
  logic [15:0] disp;
  logic [15:0] disp_n;
  logic [1:0]  mode_n;

  logic [2:0]  hi;
  logic [15:0] hi_digits;
  logic [1:0]  hi_mode;
  logic [15:0] cur_digits;
  logic [1:0]  cur_mode;
  logic        greq;
  logic        higher;
  logic        any_req;

  // Lowest set bit of req is the highest-priority requester.
  assign hi      = req & (~req + 3'd1);
  assign any_req = |req;
  assign greq    = |(req & gnt);
  assign higher  = |(req & (gnt - 3'd1));
  assign cnt_dec = (tick && cnt != 8'd0) ? cnt - 8'd1 : cnt;

  always_comb begin
    hi_digits = 16'h0000;
    hi_mode   = 2'b00;
    case (hi)
      3'b001: begin
        hi_digits = digits0;
        hi_mode   = mode0;
      end
      3'b010: begin
        hi_digits = digits1;
        hi_mode   = mode1;
      end
      3'b100: begin
        hi_digits = digits2;
        hi_mode   = mode2;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_digits = 16'h0000;
    cur_mode   = 2'b00;
    case (gnt)
      3'b001: begin
        cur_digits = digits0;
        cur_mode   = mode0;
      end
      3'b010: begin
        cur_digits = digits1;
        cur_mode   = mode1;
      end
      3'b100: begin
        cur_digits = digits2;
        cur_mode   = mode2;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = cnt_dec;
    disp_n  = disp;
    mode_n  = mode;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = SHOW;
          gnt_n   = hi;
          cnt_n   = HOLD;
          disp_n  = hi_digits;
          mode_n  = hi_mode;
        end
      end
      SHOW: begin
        if (greq) begin
          if (cnt == 8'd0 && higher) begin
            gnt_n  = hi;
            cnt_n  = HOLD;
            disp_n = hi_digits;
            mode_n = hi_mode;
          end else begin
            disp_n = cur_digits;
            mode_n = cur_mode;
          end
        end else if (cnt != 8'd0) begin
          state_n = LINGER;
        end else if (any_req) begin
          gnt_n  = hi;
          cnt_n  = HOLD;
          disp_n = hi_digits;
          mode_n = hi_mode;
        end else begin
          state_n = IDLE;
          gnt_n   = 3'b000;
          cnt_n   = 8'd0;
          disp_n  = 16'h0000;
          mode_n  = IDLE_MODE;
        end
      end
      LINGER: begin
        // Reassertion resumes the old grant without a fresh hold.
        if (greq) begin
          state_n = SHOW;
          disp_n  = cur_digits;
          mode_n  = cur_mode;
        end else if (cnt != 8'd0) begin
          state_n = LINGER;
        end else if (any_req) begin
          state_n = SHOW;
          gnt_n   = hi;
          cnt_n   = HOLD;
          disp_n  = hi_digits;
          mode_n  = hi_mode;
        end else begin
          state_n = IDLE;
          gnt_n   = 3'b000;
          cnt_n   = 8'd0;
          disp_n  = 16'h0000;
          mode_n  = IDLE_MODE;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 3'b000;
        cnt_n   = 8'd0;
        disp_n  = 16'h0000;
        mode_n  = IDLE_MODE;
      end
    endcase
  end

  always_ff @(posedge f_clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 3'b000;
      cnt   <= 8'd0;
      disp  <= 16'h0000;
      mode  <= IDLE_MODE;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      cnt   <= cnt_n;
      disp  <= disp_n;
      mode  <= mode_n;
    end
  end

  assign seg1 = disp[3:0];
  assign seg2 = disp[7:4];
  assign seg3 = disp[11:8];
  assign seg4 = disp[15:12];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a HOLD_TICKS=2 instance
// and a HOLD_TICKS=0 instance sharing clock, reset and payloads.
module tb_display_arbiter;

  logic        f_clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [2:0]  req;
  logic [2:0]  req_b;
  logic [15:0] digits0, digits1, digits2;
  logic [1:0]  mode0, mode1, mode2;

  logic [2:0]  gnt_a, gnt_b;
  logic [3:0]  s1_a, s2_a, s3_a, s4_a;
  logic [3:0]  s1_b, s2_b, s3_b, s4_b;
  logic [1:0]  mode_a, mode_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 f_clk = ~f_clk;

  display_arbiter #(.HOLD_TICKS(2), .IDLE_MODE(2'b10)) u_dut (
    .f_clk(f_clk), .rst(rst), .tick(tick), .req(req),
    .digits0(digits0), .digits1(digits1), .digits2(digits2),
    .mode0(mode0), .mode1(mode1), .mode2(mode2),
    .gnt(gnt_a), .seg1(s1_a), .seg2(s2_a), .seg3(s3_a), .seg4(s4_a),
    .mode(mode_a), .busy(busy_a)
  );

  display_arbiter #(.HOLD_TICKS(0), .IDLE_MODE(2'b00)) u_dut0 (
    .f_clk(f_clk), .rst(rst), .tick(tick), .req(req_b),
    .digits0(digits0), .digits1(digits1), .digits2(digits2),
    .mode0(mode0), .mode1(mode1), .mode2(mode2),
    .gnt(gnt_b), .seg1(s1_b), .seg2(s2_b), .seg3(s3_b), .seg4(s4_b),
    .mode(mode_b), .busy(busy_b)
  );

  task automatic cyc();
    @(posedge f_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output bundle of instance A: {gnt, digits, mode, busy}
  function automatic logic [31:0] pa();
    return {9'd0, gnt_a, s4_a, s3_a, s2_a, s1_a, mode_a, busy_a};
  endfunction

  function automatic logic [31:0] ea(input logic [2:0] g,
    input logic [15:0] d, input logic [1:0] m, input logic b);
    return {9'd0, g, d, m, b};
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; req = 3'b000; req_b = 3'b000;
    digits0 = 16'h0000; digits1 = 16'h0000; digits2 = 16'h0000;
    mode0 = 2'b00; mode1 = 2'b00; mode2 = 2'b00;
    cyc(); cyc();
    chk("reset_a", pa(), ea(3'b000, 16'h0000, 2'b10, 1'b0));
    chk("reset_b", {gnt_b, mode_b, busy_b}, {3'b000, 2'b00, 1'b0});

    rst = 1'b0;
    digits2 = 16'h4321; mode2 = 2'b01; req = 3'b100;
    cyc();
    chk("grant_src2", pa(), ea(3'b100, 16'h4321, 2'b01, 1'b1));

    digits0 = 16'hAAAA; mode0 = 2'b11; req = 3'b101;
    cyc();
    chk("no_preempt_0", pa(), ea(3'b100, 16'h4321, 2'b01, 1'b1));
    digits2 = 16'h5678;
    cyc();
    chk("track_src2", pa(), ea(3'b100, 16'h5678, 2'b01, 1'b1));
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("no_preempt_t1", {29'd0, gnt_a}, {29'd0, 3'b100});
    cyc();
    chk("no_preempt_1", {29'd0, gnt_a}, {29'd0, 3'b100});
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("no_preempt_t2", {29'd0, gnt_a}, {29'd0, 3'b100});
    cyc();
    chk("preempt_src0", pa(), ea(3'b001, 16'hAAAA, 2'b11, 1'b1));

    req = 3'b001;
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    chk("hold_src0", {29'd0, gnt_a}, {29'd0, 3'b001});

    digits1 = 16'h1357; mode1 = 2'b01; req = 3'b010; tick = 1'b1;
    cyc(); tick = 1'b0;
    chk("release_to_src1", pa(), ea(3'b010, 16'h1357, 2'b01, 1'b1));

    req = 3'b000;
    cyc();
    chk("linger_enter", pa(), ea(3'b010, 16'h1357, 2'b01, 1'b1));
    digits1 = 16'h2468; mode1 = 2'b11;
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("linger_frozen", pa(), ea(3'b010, 16'h1357, 2'b01, 1'b1));

    digits1 = 16'h9999; req = 3'b010;
    cyc();
    chk("linger_resume", pa(), ea(3'b010, 16'h9999, 2'b11, 1'b1));
    req = 3'b000;
    cyc();
    chk("linger_again", pa(), ea(3'b010, 16'h9999, 2'b11, 1'b1));
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("linger_cnt0", pa(), ea(3'b010, 16'h9999, 2'b11, 1'b1));
    cyc();
    chk("linger_expire", pa(), ea(3'b000, 16'h0000, 2'b10, 1'b0));

    req = 3'b010;
    cyc();
    chk("regrant_src1", pa(), ea(3'b010, 16'h9999, 2'b11, 1'b1));
    rst = 1'b1; tick = 1'b1;
    cyc();
    chk("reset_mid_show", pa(), ea(3'b000, 16'h0000, 2'b10, 1'b0));
    rst = 1'b0; tick = 1'b0;
    cyc();
    chk("restart_after_rst", pa(), ea(3'b010, 16'h9999, 2'b11, 1'b1));

    req = 3'b000;
    req_b = 3'b001;
    cyc();
    chk("h0_gnt_001", {27'd0, gnt_b, mode_b}, {27'd0, 3'b001, 2'b11});
    req_b = 3'b010;
    cyc();
    chk("h0_gnt_010", {29'd0, gnt_b}, {29'd0, 3'b010});
    req_b = 3'b000;
    cyc();
    chk("h0_gnt_000", {28'd0, gnt_b, busy_b}, {28'd0, 3'b000, 1'b0});
    req_b = 3'b100;
    cyc();
    chk("h0_gnt_100", {29'd0, gnt_b}, {29'd0, 3'b100});
    req_b = 3'b101;
    cyc();
    chk("h0_preempt", {13'd0, gnt_b, s4_b, s3_b, s2_b, s1_b},
        {13'd0, 3'b001, 16'hAAAA});
    req_b = 3'b000;
    cyc();
    chk("h0_release", {29'd0, gnt_b}, {29'd0, 3'b000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
